lvt_wr_dispatch: RTL and testbench

Upstream write scheduler for lvt_bram. Accepts a single in-order stream of write requests through a valid/ready handshake and buffers them in a FIFO. Each cycle it pops up to two requests and drives them onto the wr0/wr1 ports of the two-write-port LVT memory. It also provides a pending-write hazard check so the read requester can hold rd0 until an in-flight write to the same address has landed.

---
 rtl/lvt_wr_dispatch.sv | 145 ++++++++++++++
 tb/tb_lvt_wr_dispatch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvt_wr_dispatch.sv
// lvt_wr_dispatch: write scheduler in front of the two-write-port LVT memory.
// Buffers an in-order write stream in a FIFO and each cycle pops up to two
// requests onto wr0 (older) and wr1 (younger). It also exposes a
// pending-write hazard check for the read side.
// Optional build macro: LVT_WR_COALESCE_EN. When it is defined, two adjacent
// writes to the same address are merged, so only the younger write issues.
module lvt_wr_dispatch #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 5,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              issue_en,
  output logic              wr0_en,
  output logic [ADDR_W-1:0] wr0_addr,
  output logic [DATA_W-1:0] wr0_data,
  output logic              wr1_en,
  output logic [ADDR_W-1:0] wr1_addr,
  output logic [DATA_W-1:0] wr1_data,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_hit,
  output logic              busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage. It has no reset: count alone decides which entries are live.
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PW-1:0] wptr, rptr, rptr_n1;
  logic [CW-1:0] count;

  logic              push;
  logic              iss0, iss1;
  logic [1:0]        npop;
  logic [ADDR_W-1:0] head_addr, next_addr;
  logic [DATA_W-1:0] head_data, next_data;

  assign rptr_n1   = rptr + PW'(1);
  assign head_addr = addr_mem[rptr];
  assign head_data = data_mem[rptr];
  assign next_addr = addr_mem[rptr_n1];
  assign next_data = data_mem[rptr_n1];

  // Acceptance depends only on the current occupancy, so a full FIFO refuses
  // a push even if it pops in the same cycle.
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid & in_ready;

  // Issue decision, taken from FIFO contents before the edge. This means a
  // request that was just pushed can never bypass the FIFO.
  always_comb begin
    iss0 = 1'b0;
    iss1 = 1'b0;
    npop = 2'd0;
    if (issue_en && (count != '0)) begin
      if (count == CW'(1)) begin
        iss0 = 1'b1;
        npop = 2'd1;
      end else if (head_addr != next_addr) begin
        iss0 = 1'b1;
        iss1 = 1'b1;
        npop = 2'd2;
      end else begin
`ifdef LVT_WR_COALESCE_EN
        // The older write would be overwritten anyway, so drop it and send
        // only the younger one on wr1.
        iss1 = 1'b1;
        npop = 2'd2;
`else
        // Serialise same-address writes so that both reach memory in order.
        iss0 = 1'b1;
        npop = 2'd1;
`endif
      end
    end
  end

  // Write payload into the tail slot on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr] <= in_addr;
      data_mem[wptr] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping. Reset drops every buffered request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      rptr  <= rptr + PW'(npop);
      count <= count + CW'(push) - CW'(npop);
    end
  end

  // Registered write ports. The enables pulse for one cycle per issued slot,
  // and addr/data hold their last value while a port is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr0_en   <= 1'b0;
      wr0_addr <= '0;
      wr0_data <= '0;
      wr1_en   <= 1'b0;
      wr1_addr <= '0;
      wr1_data <= '0;
    end else begin
      wr0_en <= iss0;
      wr1_en <= iss1;
      if (iss0) begin
        wr0_addr <= head_addr;
        wr0_data <= head_data;
      end
      if (iss1) begin
        wr1_addr <= next_addr;
        wr1_data <= next_data;
      end
    end
  end

  // Hazard check against every live FIFO entry plus any write landing this cycle.
  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (addr_mem[rptr + PW'(i)] == chk_addr)) hit = 1'b1;
    end
    if (wr0_en && (wr0_addr == chk_addr)) hit = 1'b1;
    if (wr1_en && (wr1_addr == chk_addr)) hit = 1'b1;
    chk_hit = rst & hit;
  end

  assign busy = (count != '0) | wr0_en | wr1_en;

endmodule

// File: tb/tb_lvt_wr_dispatch.sv
// Directed bench for lvt_wr_dispatch (default parameters: 7-bit address,
// 5-bit data, 8 entries). Inputs change 1ns after the rising edge, and
// outputs are sampled there too.
module tb_lvt_wr_dispatch;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_addr;
  logic [4:0] in_data;
  logic       issue_en;
  logic       wr0_en, wr1_en;
  logic [6:0] wr0_addr, wr1_addr;
  logic [4:0] wr0_data, wr1_data;
  logic [6:0] chk_addr;
  logic       chk_hit;
  logic       busy;

  int total = 0;
  int bad   = 0;

  lvt_wr_dispatch #(.ADDR_W(7), .DATA_W(5), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .issue_en(issue_en),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .chk_addr(chk_addr), .chk_hit(chk_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] a, input logic [4:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    issue_en = 1'b0; chk_addr = '0;
    tick(); tick();
    total++;
    if ({wr0_en, wr1_en, in_ready, busy, chk_hit} !== 5'b00100) begin
      bad++;
      $display("FAIL reset: {wr0_en,wr1_en,in_ready,busy,chk_hit}=%b want 00100",
               {wr0_en, wr1_en, in_ready, busy, chk_hit});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_dual_issue();
    issue_en = 1'b0;
    push(7'd10, 5'd5);
    push(7'd20, 5'd10);
    issue_en = 1'b1;
    chk_addr = 7'd20;
    tick();
    total++;
    if ({wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data} !==
        {1'b1, 7'd10, 5'd5, 1'b1, 7'd20, 5'd10}) begin
      bad++;
      $display("FAIL dual_issue: wr0=%b/%0d/%0d wr1=%b/%0d/%0d want 1/10/5 1/20/10",
               wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data);
    end
    total++;
    if (chk_hit !== 1'b1) begin
      bad++;
      $display("FAIL chk_wr1: chk_hit=%b want 1", chk_hit);
    end
    tick();
    total++;
    if ({wr0_en, wr1_en, busy} !== 3'b000) begin
      bad++;
      $display("FAIL dual_after: {wr0_en,wr1_en,busy}=%b want 000", {wr0_en, wr1_en, busy});
    end
  endtask

  task automatic test_same_addr();
    issue_en = 1'b0;
    push(7'd30, 5'd15);
    push(7'd30, 5'd16);
    issue_en = 1'b1;
    tick();
`ifdef LVT_WR_COALESCE_EN
    total++;
    if ({wr0_en, wr1_en, wr1_addr, wr1_data} !== {1'b0, 1'b1, 7'd30, 5'd16}) begin
      bad++;
      $display("FAIL coalesce: wr0_en=%b wr1=%b/%0d/%0d want 0 1/30/16",
               wr0_en, wr1_en, wr1_addr, wr1_data);
    end
`else
    total++;
    if ({wr0_en, wr0_addr, wr0_data, wr1_en} !== {1'b1, 7'd30, 5'd15, 1'b0}) begin
      bad++;
      $display("FAIL same_addr_1: wr0=%b/%0d/%0d wr1_en=%b want 1/30/15 0",
               wr0_en, wr0_addr, wr0_data, wr1_en);
    end
    tick();
    total++;
    if ({wr0_en, wr0_addr, wr0_data, wr1_en} !== {1'b1, 7'd30, 5'd16, 1'b0}) begin
      bad++;
      $display("FAIL same_addr_2: wr0=%b/%0d/%0d wr1_en=%b want 1/30/16 0",
               wr0_en, wr0_addr, wr0_data, wr1_en);
    end
`endif
    tick();
    total++;
    if ({wr0_en, wr1_en, busy} !== 3'b000) begin
      bad++;
      $display("FAIL same_addr_after: {wr0_en,wr1_en,busy}=%b want 000", {wr0_en, wr1_en, busy});
    end
  endtask

  // Pushes one request per cycle while issue is enabled. There is no bypass,
  // so each request appears on wr0 exactly one edge after it is pushed.
  task automatic test_back_to_back();
    issue_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k < 3);
      in_addr  = 7'(80 + k);
      in_data  = 5'(k);
      tick();
      total++;
      if (k == 0 || k == 4) begin
        if ({wr0_en, wr1_en} !== 2'b00) begin
          bad++;
          $display("FAIL b2b_idle k=%0d: wr0_en=%b wr1_en=%b want 0 0", k, wr0_en, wr1_en);
        end
      end else begin
        if ({wr0_en, wr0_addr, wr0_data, wr1_en} !== {1'b1, 7'(80 + k - 1), 5'(k - 1), 1'b0}) begin
          bad++;
          $display("FAIL b2b k=%0d: wr0=%b/%0d/%0d wr1_en=%b want 1/%0d/%0d 0",
                   k, wr0_en, wr0_addr, wr0_data, wr1_en, 80 + k - 1, k - 1);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_wrap();
    for (int pass = 0; pass < 2; pass++) begin
      issue_en = 1'b0;
      for (int i = 0; i < 8; i++) push(7'(40 + 20 * pass + i), 5'(8 * pass + i));
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL full pass=%0d: in_ready=%b want 0", pass, in_ready);
      end
      if (pass == 0) begin
        push(7'd48, 5'd1);
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL overflow: in_ready=%b want 0", in_ready);
        end
      end
      issue_en = 1'b1;
      for (int j = 0; j < 4; j++) begin
        tick();
        total++;
        if ({wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data} !==
            {1'b1, 7'(40 + 20 * pass + 2 * j), 5'(8 * pass + 2 * j),
             1'b1, 7'(41 + 20 * pass + 2 * j), 5'(8 * pass + 2 * j + 1)}) begin
          bad++;
          $display("FAIL drain pass=%0d j=%0d: wr0=%b/%0d/%0d wr1=%b/%0d/%0d want 1/%0d/%0d 1/%0d/%0d",
                   pass, j, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
                   40 + 20 * pass + 2 * j, 8 * pass + 2 * j,
                   41 + 20 * pass + 2 * j, 8 * pass + 2 * j + 1);
        end
      end
      tick();
      total++;
      if ({wr0_en, wr1_en, busy, in_ready} !== 4'b0001) begin
        bad++;
        $display("FAIL drain_end pass=%0d: {wr0_en,wr1_en,busy,in_ready}=%b want 0001",
                 pass, {wr0_en, wr1_en, busy, in_ready});
      end
    end
  endtask

  task automatic test_hazard();
    issue_en = 1'b0;
    push(7'd50, 5'd25);
    chk_addr = 7'd50;
    #1;
    total++;
    if (chk_hit !== 1'b1) begin
      bad++;
      $display("FAIL hazard_fifo: chk_hit=%b want 1", chk_hit);
    end
    chk_addr = 7'd55;
    #1;
    total++;
    if (chk_hit !== 1'b0) begin
      bad++;
      $display("FAIL hazard_miss: chk_hit=%b want 0", chk_hit);
    end
    chk_addr = 7'd50;
    issue_en = 1'b1;
    tick();
    total++;
    if ({wr0_en, chk_hit} !== 2'b11) begin
      bad++;
      $display("FAIL hazard_wr0: {wr0_en,chk_hit}=%b want 11", {wr0_en, chk_hit});
    end
    tick();
    total++;
    if ({wr0_en, chk_hit} !== 2'b00) begin
      bad++;
      $display("FAIL hazard_clear: {wr0_en,chk_hit}=%b want 00", {wr0_en, chk_hit});
    end
  endtask

  task automatic test_mid_reset();
    issue_en = 1'b0;
    push(7'd70, 5'd1);
    push(7'd71, 5'd2);
    push(7'd72, 5'd3);
    issue_en = 1'b1;
    tick();
    total++;
    if ({wr0_en, wr0_addr, wr1_en, wr1_addr} !== {1'b1, 7'd70, 1'b1, 7'd71}) begin
      bad++;
      $display("FAIL pre_reset: wr0=%b/%0d wr1=%b/%0d want 1/70 1/71",
               wr0_en, wr0_addr, wr1_en, wr1_addr);
    end
    chk_addr = 7'd72;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({wr0_en, wr1_en, busy, in_ready, chk_hit, wr0_addr} !== {5'b00010, 7'd0}) begin
      bad++;
      $display("FAIL async_reset: {wr0_en,wr1_en,busy,in_ready,chk_hit}=%b wr0_addr=%0d want 00010 0",
               {wr0_en, wr1_en, busy, in_ready, chk_hit}, wr0_addr);
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({wr0_en, wr1_en, busy} !== 3'b000) begin
        bad++;
        $display("FAIL post_reset c=%0d: {wr0_en,wr1_en,busy}=%b want 000", c, {wr0_en, wr1_en, busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_dual_issue();
    test_same_addr();
    test_back_to_back();
    test_full_wrap();
    test_hazard();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
